// File: rtl/cache_controller_stage2_param.sv
// cache_controller_stage2_param: L1 cache-controller stage 2.
// Per request: snoop tag hit / lowest hit way, pLRU victim way, MSHR
// replacement-collision flag and the coherence states of the addressed set.
// Coherence state and pLRU bits live in flop arrays, so lookups are
// combinational and the single output register can stall under backpressure.
// Optional feature: define CC2_STATE_BYPASS_EN to forward a same-cycle state
// write to the captured states (write-first); otherwise the old value is seen.
module cache_controller_stage2_param #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  parameter int TAG_W    = 20,
  parameter int STATE_W  = 4,
  parameter int ID_W     = 16,
  localparam int SET_W   = $clog2(NUM_SETS),
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic [SET_W-1:0]            in_set,
  input  logic [ID_W-1:0]             in_id,
  input  logic [NUM_WAYS*TAG_W-1:0]   snoop_tag,
  input  logic [NUM_WAYS-1:0]         snoop_valid,
  output logic [TAG_W-1:0]            victim_tag,
  output logic [SET_W-1:0]            victim_set,
  input  logic                        mshr_collision_hit,
  input  logic                        upd_state_en,
  input  logic [SET_W-1:0]            upd_state_set,
  input  logic [WAY_W-1:0]            upd_state_way,
  input  logic [STATE_W-1:0]          upd_state,
  input  logic                        lru_fill_en,
  input  logic                        lru_upd_en,
  input  logic [SET_W-1:0]            lru_upd_set,
  input  logic [WAY_W-1:0]            lru_upd_way,
  output logic                        pending_valid,
  output logic [SET_W-1:0]            pending_set,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TAG_W-1:0]            out_tag,
  output logic [SET_W-1:0]            out_set,
  output logic [ID_W-1:0]             out_id,
  output logic                        out_hit,
  output logic [WAY_W-1:0]            out_hit_way,
  output logic [WAY_W-1:0]            out_lru_way,
  output logic                        out_collision,
  output logic [NUM_WAYS*STATE_W-1:0] out_states
);

  localparam int LRU_W = NUM_WAYS - 1;
  localparam int ROW_W = NUM_WAYS * STATE_W;

  logic [LRU_W-1:0] lru_q   [NUM_SETS];
  logic [ROW_W-1:0] state_q [NUM_SETS];

  // Heap-ordered tree: node n has children 2n+1 (lower ways) and 2n+2.
  // A node bit of 0 sends the victim search to the lower-index subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [LRU_W-1:0] bits);
    logic [WAY_W-1:0] way;
    logic             dir;
    int               node;
    way  = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir  = ((bits >> node) & LRU_W'(1)) != '0;
      way  = (way << 1) | WAY_W'(dir);
      node = 2 * node + 1 + int'(dir);
    end
    return way;
  endfunction

  // Every node on the path to the touched way is pointed at the other half.
  function automatic logic [LRU_W-1:0] plru_touch(input logic [LRU_W-1:0] bits,
                                                  input logic [WAY_W-1:0] w);
    logic [LRU_W-1:0] r;
    logic             dir;
    int               node;
    r    = bits;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir  = ((w >> (WAY_W - 1 - lvl)) & WAY_W'(1)) != '0;
      r    = (r & ~(LRU_W'(1) << node)) | (LRU_W'(!dir) << node);
      node = 2 * node + 1 + int'(dir);
    end
    return r;
  endfunction

  logic                 vld_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic [SET_W-1:0]     set_p1;
  logic [ID_W-1:0]      id_p1;
  logic                 hit_p1;
  logic [WAY_W-1:0]     hit_way_p1;
  logic [WAY_W-1:0]     lru_way_p1;
  logic                 coll_p1;
  logic [ROW_W-1:0]     states_p1;

  logic                 capture;
  logic                 hit_c;
  logic [WAY_W-1:0]     hit_way_c;
  logic [WAY_W-1:0]     lru_way_c;
  logic [ROW_W-1:0]     state_row_wr;
  logic [ROW_W-1:0]     states_c;

  assign in_ready      = !vld_p1 || out_ready;
  assign capture       = in_valid && in_ready;
  assign pending_valid = capture;
  assign pending_set   = in_set;
  assign victim_set    = in_set;
  assign lru_way_c     = plru_victim(lru_q[in_set]);

  // Tag compare across the snooped ways; the lowest matching way wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (snoop_valid[w] && snoop_tag[w*TAG_W +: TAG_W] == in_tag) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  // MSHR lookup tag of the victim way, zero when that way holds nothing.
  always_comb begin
    victim_tag = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (lru_way_c == WAY_W'(w) && snoop_valid[w])
        victim_tag = snoop_tag[w*TAG_W +: TAG_W];
    end
  end

  // Row of the written set with the incoming state merged into its way.
  always_comb begin
    state_row_wr = state_q[upd_state_set];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (upd_state_way == WAY_W'(w))
        state_row_wr[w*STATE_W +: STATE_W] = upd_state;
    end
  end

  // States handed to stage 3: stored row, optionally with same-cycle write forwarded.
  always_comb begin
    states_c = state_q[in_set];
`ifdef CC2_STATE_BYPASS_EN
    if (upd_state_en && upd_state_set == in_set)
      states_c = state_row_wr;
`endif
  end

  // pLRU maintenance; a stage-3 fill touch suppresses any LDST touch that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) lru_q[s] <= '0;
    end else if (lru_fill_en) begin
      lru_q[upd_state_set] <= plru_touch(lru_q[upd_state_set], upd_state_way);
    end else if (lru_upd_en) begin
      lru_q[lru_upd_set] <= plru_touch(lru_q[lru_upd_set], lru_upd_way);
    end
  end

  // Coherence state writes from stage 3, independent of the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) state_q[s] <= '0;
    end else if (upd_state_en) begin
      state_q[upd_state_set] <= state_row_wr;
    end
  end

  // ---- stage boundary: lookup results registered toward stage 3 ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      tag_p1     <= '0;
      set_p1     <= '0;
      id_p1      <= '0;
      hit_p1     <= 1'b0;
      hit_way_p1 <= '0;
      lru_way_p1 <= '0;
      coll_p1    <= 1'b0;
      states_p1  <= '0;
    end else if (capture) begin
      vld_p1     <= 1'b1;
      tag_p1     <= in_tag;
      set_p1     <= in_set;
      id_p1      <= in_id;
      hit_p1     <= hit_c;
      hit_way_p1 <= hit_way_c;
      lru_way_p1 <= lru_way_c;
      coll_p1    <= mshr_collision_hit;
      states_p1  <= states_c;
    end else if (out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign out_valid     = vld_p1;
  assign out_tag       = tag_p1;
  assign out_set       = set_p1;
  assign out_id        = id_p1;
  assign out_hit       = hit_p1;
  assign out_hit_way   = hit_way_p1;
  assign out_lru_way   = lru_way_p1;
  assign out_collision = coll_p1;
  assign out_states    = states_p1;

endmodule

// File: tb/tb_cache_controller_stage2_param.sv
// Bench for cache_controller_stage2_param: directed cases with literal
// expectations followed by randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_cache_controller_stage2_param;
  localparam int NUM_SETS = 64;
  localparam int NUM_WAYS = 4;
  localparam int TAG_W    = 20;
  localparam int STATE_W  = 4;
  localparam int ID_W     = 16;
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int WAY_W    = $clog2(NUM_WAYS);

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        in_valid, in_ready;
  logic [TAG_W-1:0]            in_tag;
  logic [SET_W-1:0]            in_set;
  logic [ID_W-1:0]             in_id;
  logic [NUM_WAYS*TAG_W-1:0]   snoop_tag;
  logic [NUM_WAYS-1:0]         snoop_valid;
  logic [TAG_W-1:0]            victim_tag;
  logic [SET_W-1:0]            victim_set;
  logic                        mshr_collision_hit;
  logic                        upd_state_en;
  logic [SET_W-1:0]            upd_state_set;
  logic [WAY_W-1:0]            upd_state_way;
  logic [STATE_W-1:0]          upd_state;
  logic                        lru_fill_en, lru_upd_en;
  logic [SET_W-1:0]            lru_upd_set;
  logic [WAY_W-1:0]            lru_upd_way;
  logic                        pending_valid;
  logic [SET_W-1:0]            pending_set;
  logic                        out_valid, out_ready;
  logic [TAG_W-1:0]            out_tag;
  logic [SET_W-1:0]            out_set;
  logic [ID_W-1:0]             out_id;
  logic                        out_hit;
  logic [WAY_W-1:0]            out_hit_way, out_lru_way;
  logic                        out_collision;
  logic [NUM_WAYS*STATE_W-1:0] out_states;

  always #5 clk = ~clk;

  cache_controller_stage2_param #(
    .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .TAG_W(TAG_W),
    .STATE_W(STATE_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_set(in_set),
    .in_id(in_id), .snoop_tag(snoop_tag), .snoop_valid(snoop_valid),
    .victim_tag(victim_tag), .victim_set(victim_set),
    .mshr_collision_hit(mshr_collision_hit),
    .upd_state_en(upd_state_en), .upd_state_set(upd_state_set),
    .upd_state_way(upd_state_way), .upd_state(upd_state),
    .lru_fill_en(lru_fill_en), .lru_upd_en(lru_upd_en),
    .lru_upd_set(lru_upd_set), .lru_upd_way(lru_upd_way),
    .pending_valid(pending_valid), .pending_set(pending_set),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_set(out_set), .out_id(out_id), .out_hit(out_hit),
    .out_hit_way(out_hit_way), .out_lru_way(out_lru_way),
    .out_collision(out_collision), .out_states(out_states)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: per-set tree node directions (indexed level-by-level by the
  // way prefix) and per-way coherence states; plus the expected output register.
  int                          lru_dir [NUM_SETS][NUM_WAYS];
  int                          st      [NUM_SETS][NUM_WAYS];
  logic                        e_valid, e_hit, e_coll;
  logic [TAG_W-1:0]            e_tag;
  logic [SET_W-1:0]            e_set;
  logic [ID_W-1:0]             e_id;
  int                          e_hit_way, e_lru;
  logic [NUM_WAYS*STATE_W-1:0] e_states;

  function automatic int m_victim(input int s);
    int w = 0;
    for (int l = 0; l < WAY_W; l++) w = 2 * w + lru_dir[s][(1 << l) - 1 + w];
    return w;
  endfunction

  task automatic m_touch(input int s, input int w);
    for (int l = 0; l < WAY_W; l++)
      lru_dir[s][(1 << l) - 1 + (w >> (WAY_W - l))] = 1 - ((w >> (WAY_W - 1 - l)) & 1);
  endtask

  function automatic logic [TAG_W-1:0] m_victim_tag(input int s);
    int v = m_victim(s);
    return snoop_valid[v] ? snoop_tag[v*TAG_W +: TAG_W] : '0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++) begin
        lru_dir[s][w] = 0;
        st[s][w]      = 0;
      end
    e_valid = 0; e_hit = 0; e_coll = 0; e_tag = '0; e_set = '0; e_id = '0;
    e_hit_way = 0; e_lru = 0; e_states = '0;
  endtask

  // Applied at each active edge using the inputs that were present at it.
  task automatic model_edge();
    logic rdy;
    if (reset) return;
    rdy = !e_valid || out_ready;
    if (in_valid && rdy) begin
      e_valid = 1; e_tag = in_tag; e_set = in_set; e_id = in_id;
      e_coll = mshr_collision_hit;
      e_lru = m_victim(in_set);
      e_hit = 0; e_hit_way = 0;
      for (int w = 0; w < NUM_WAYS; w++)
        if (!e_hit && snoop_valid[w] && snoop_tag[w*TAG_W +: TAG_W] == in_tag) begin
          e_hit = 1; e_hit_way = w;
        end
      for (int w = 0; w < NUM_WAYS; w++) e_states[w*STATE_W +: STATE_W] = STATE_W'(st[in_set][w]);
`ifdef CC2_STATE_BYPASS_EN
      if (upd_state_en && upd_state_set == in_set)
        e_states[int'(upd_state_way)*STATE_W +: STATE_W] = upd_state;
`endif
    end else if (out_ready) begin
      e_valid = 0;
    end
    if (lru_fill_en) m_touch(upd_state_set, upd_state_way);
    else if (lru_upd_en) m_touch(lru_upd_set, lru_upd_way);
    if (upd_state_en) st[upd_state_set][upd_state_way] = upd_state;
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", in_ready, !e_valid || out_ready);
    chk("pending_valid", pending_valid, in_valid && (!e_valid || out_ready));
    chk("pending_set", pending_set, in_set);
    if (in_valid) begin
      chk("victim_set", victim_set, in_set);
      chk("victim_tag", victim_tag, m_victim_tag(in_set));
    end
    chk("out_valid", out_valid, e_valid);
    chk("out_tag", out_tag, e_tag);
    chk("out_set", out_set, e_set);
    chk("out_id", out_id, e_id);
    chk("out_hit", out_hit, e_hit);
    chk("out_hit_way", out_hit_way, e_hit_way);
    chk("out_lru_way", out_lru_way, e_lru);
    chk("out_collision", out_collision, e_coll);
    chk("out_states", out_states, e_states);
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; out_ready = 1; in_tag = '0; in_set = '0; in_id = '0;
    snoop_tag = '0; snoop_valid = '0; mshr_collision_hit = 0;
    upd_state_en = 0; upd_state_set = '0; upd_state_way = '0; upd_state = '0;
    lru_fill_en = 0; lru_upd_en = 0; lru_upd_set = '0; lru_upd_way = '0;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    model_reset();
    @(posedge clk);
    #2 reset = 0;
  endtask

  task automatic touch_seq(input int s, input int a, input int b, input int c);
    int ws [3];
    ws[0] = a; ws[1] = b; ws[2] = c;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      lru_upd_en = 1; lru_upd_set = SET_W'(s); lru_upd_way = WAY_W'(ws[i]);
      step();
    end
    idle_inputs();
  endtask

  task automatic request(input int s, input int tag);
    in_valid = 1; in_set = SET_W'(s); in_tag = TAG_W'(tag); in_id = ID_W'(s + 16'h100);
    step();
    idle_inputs();
  endtask

  int bypass_exp;

  initial begin
    idle_inputs();
    reset = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;

    chk("reset_out_valid", out_valid, 0);
    chk("reset_lru_way", out_lru_way, 0);
    chk("reset_states", out_states, 0);

    // First request on a fresh set with nothing valid.
    in_valid = 1; in_set = 5; in_tag = 20'hABC; in_id = 16'h1234;
    step();
    idle_inputs();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_hit", out_hit, 0);
    chk("t1_out_lru_way", out_lru_way, 0);
    chk("t1_out_states", out_states, 0);
    chk("t1_out_id", out_id, 16'h1234);

    // Two valid matching ways: the lower one is reported.
    for (int w = 0; w < NUM_WAYS; w++) snoop_tag[w*TAG_W +: TAG_W] = 20'hABC;
    snoop_valid = 4'b1100;
    in_valid = 1; in_set = 6; in_tag = 20'hABC;
    step();
    idle_inputs();
    chk("t2_out_hit", out_hit, 1);
    chk("t2_out_hit_way", out_hit_way, 2);

    // Touch 0,1,2: root points left (away from 2), left node points to 0.
    touch_seq(9, 0, 1, 2);
    request(9, 1);
    chk("t3_lru_after_012", out_lru_way, 0);
    // Fill way3 with a concurrent LDST touch on way0: only the fill lands.
    lru_fill_en = 1; upd_state_set = 9; upd_state_way = 3;
    lru_upd_en = 1; lru_upd_set = 9; lru_upd_way = 0;
    step();
    idle_inputs();
    request(9, 1);
    chk("t3_fill_priority", out_lru_way, 0);
    // Touch 0,2,1: root points right (away from 1), right node points to 3.
    touch_seq(10, 0, 2, 1);
    request(10, 1);
    chk("t3_lru_after_021", out_lru_way, 3);
    // Fill on set 12 drops an LDST touch on a different set 13.
    lru_fill_en = 1; upd_state_set = 12; upd_state_way = 1;
    lru_upd_en = 1; lru_upd_set = 13; lru_upd_way = 0;
    step();
    idle_inputs();
    request(13, 1);
    chk("t3_drop_other_set", out_lru_way, 0);
    request(12, 1);
    chk("t3_fill_other_set", out_lru_way, 2);

    // Backpressure: hold A for three cycles while B waits, then hand over.
    step();
    in_valid = 1; in_set = 20; in_tag = 20'h111; in_id = 16'h0001; out_ready = 0;
    step();
    in_tag = 20'h222; in_id = 16'h0002; in_set = 21;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_stall_in_ready", in_ready, 0);
      step();
      chk("t4_hold_tag", out_tag, 20'h111);
      chk("t4_hold_valid", out_valid, 1);
    end
    out_ready = 1;
    #1 chk("t4_release_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("t4_b_tag", out_tag, 20'h222);
    chk("t4_b_id", out_id, 16'h0002);
    step();
    chk("t4_drained", out_valid, 0);
    idle_inputs();

    // State write into set 5 way 1 alongside a set-5 request.
`ifdef CC2_STATE_BYPASS_EN
    bypass_exp = 3;
`else
    bypass_exp = 0;
`endif
    in_valid = 1; in_set = 5; in_tag = 20'h5;
    upd_state_en = 1; upd_state_set = 5; upd_state_way = 1; upd_state = 4'd3;
    step();
    idle_inputs();
    chk("t5_same_cycle_state", out_states[7:4], bypass_exp);
    request(5, 5);
    chk("t5_later_state", out_states[7:4], 3);

    // Victim way 0 (fresh set) valid with tag 0x77 and an MSHR hit.
    in_valid = 1; in_set = 11; snoop_tag[TAG_W-1:0] = 20'h77; snoop_valid = 4'b0001;
    mshr_collision_hit = 1;
    #1 chk("t6_victim_tag", victim_tag, 20'h77);
    step();
    chk("t6_out_collision", out_collision, 1);
    snoop_valid = 4'b1110;
    #1 chk("t6_invalid_victim_tag", victim_tag, 0);
    step();
    idle_inputs();

    // Asynchronous reset while a request is held and another waits.
    step();
    in_valid = 1; in_set = 30; in_tag = 20'h333; out_ready = 0;
    step();
    in_tag = 20'h444;
    step();
    do_reset();
    idle_inputs();
    out_ready = 0;
    #1;
    chk("t7_in_ready_after_reset", in_ready, 1);
    chk("t7_out_valid_after_reset", out_valid, 0);
    step();
    idle_inputs();

    // Randomized traffic on a few sets with a small tag space.
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_set   = SET_W'($urandom_range(0, 3));
      in_tag   = TAG_W'($urandom_range(0, 3));
      in_id    = ID_W'($urandom);
      for (int w = 0; w < NUM_WAYS; w++)
        snoop_tag[w*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 3));
      snoop_valid        = NUM_WAYS'($urandom);
      mshr_collision_hit = 1'($urandom);
      out_ready          = ($urandom_range(0, 3) != 0);
      upd_state_en       = 1'($urandom);
      upd_state_set      = SET_W'($urandom_range(0, 3));
      upd_state_way      = WAY_W'($urandom);
      upd_state          = STATE_W'($urandom);
      lru_fill_en        = ($urandom_range(0, 3) == 0);
      lru_upd_en         = 1'($urandom);
      lru_upd_set        = SET_W'($urandom_range(0, 3));
      lru_upd_way        = WAY_W'($urandom);
      step();
    end

    idle_inputs();
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
